otp_keygen: RTL and testbench
=============================

OTP_KEYGEN -- requirements
Module: otp_keygen

Interface
REQ-001 Parameter KEY_W, 64, key width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter ROT, 8, rotate distance per advance in rotate mode; SHALL be in the range 1..KEY_W-1.
REQ-003 Parameter CNT_W, 8, width of the word-count input and the internal counter.
REQ-004 Parameter TAPS, 64'hD800_0000_0000_0000, KEY_W-bit LFSR feedback mask.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge only.
REQ-006 reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-007 start  in  1  starts a session; sampled only in IDLE.
REQ-008 seed  in  8  generator seed; sampled together with start.
REQ-009 nwords  in  CNT_W  number of key words to emit in the session.
REQ-010 mode  in  1  0 = rotate, 1 = LFSR; sampled together with start.
REQ-011 key  out  KEY_W  current key word.
REQ-012 key_valid  out  1  key holds a valid word.
REQ-013 key_ready  in  1  consumer accepts key.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at session end.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 In IDLE with start=1: shift_reg SHALL load {KEY_W/8{seed}}, the counter SHALL load nwords, and mode SHALL be latched.
REQ-018 From IDLE with start=1, the FSM SHALL go to DONE if nwords==0, otherwise to RUN.
REQ-019 Latency: start sampled in cycle n SHALL give key_valid=1 in cycle n+1.
REQ-020 In RUN, key_valid SHALL be 1 and key SHALL equal shift_reg.
REQ-021 A handshake (key_valid & key_ready) SHALL advance shift_reg once and decrement the counter.
REQ-022 Rotate mode advance: shift_reg <= {shift_reg[ROT-1:0], shift_reg[KEY_W-1:ROT]} (rotate right by ROT).
REQ-023 LFSR mode advance: shift_reg <= {^(shift_reg & TAPS), shift_reg[KEY_W-1:1]}.
REQ-024 A handshake with counter==1 SHALL move the FSM to DONE; key_valid SHALL be 0 in the following cycle.
REQ-025 While key_valid=1 and key_ready=0, key SHALL hold stable and the counter SHALL not change.
REQ-026 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-027 start SHALL be ignored in RUN and DONE, and seed, nwords and mode SHALL not be resampled.
REQ-028 In LFSR mode with seed==8'h00, 8'hFF SHALL be substituted for the seed to avoid LFSR lockup.
REQ-029 In IDLE, key SHALL retain the last shift_reg value and key_valid SHALL be 0.

Reset
REQ-030 With reset=0 at a clk edge: state SHALL be IDLE, shift_reg 0, counter 0, and key_valid, busy and done 0.
REQ-031 Reset SHALL take priority over every other input, including mid-RUN and in DONE, and SHALL produce no done pulse.

Configuration
REQ-032 Macro OTP_KEYGEN_LFSR_EN: when defined, LFSR mode and the TAPS logic SHALL be present.
REQ-033 When OTP_KEYGEN_LFSR_EN is undefined, mode SHALL be ignored, rotate mode SHALL always apply, and the zero-seed substitution SHALL be absent.

Verification (KEY_W=16, ROT=4, TAPS=16'hB400, CNT_W=8)
REQ-034 Rotate: seed=8'h12, nwords=3, key_ready=1 -> keys 16'h1212, 16'h2121, 16'h1212 on consecutive cycles, then done pulse.
REQ-035 Backpressure: key_ready=0 for 5 cycles after the first valid -> key holds 16'h1212 and the counter holds; 3 words are still delivered once key_ready=1.
REQ-036 nwords=0 with start in cycle n -> done=1 in cycle n+1, key_valid never 1, busy=0 in cycle n+2.
REQ-037 LFSR (macro defined): seed=8'h01, mode=1 -> keys 16'h0101, then 16'h0080.
REQ-038 LFSR zero seed: seed=8'h00, mode=1 -> first key 16'hFFFF; without the macro, mode=1 -> first key 16'h0000, which rotates unchanged.
REQ-039 reset=0 asserted mid-RUN after the 2nd word -> next cycle key_valid=0, busy=0, key=0, done never pulses; a new start works normally.

Source files
------------

// File: rtl/otp_keygen.sv
// otp_keygen: session-based key word generator (rotate or LFSR advance) with valid/ready output.
// Define OTP_KEYGEN_LFSR_EN to build the LFSR mode and zero-seed substitution; otherwise rotate only.
module otp_keygen #(
  parameter int unsigned      KEY_W = 64,
  parameter int unsigned      ROT   = 8,
  parameter int unsigned      CNT_W = 8,
  parameter logic [KEY_W-1:0] TAPS  = KEY_W'(64'hD800_0000_0000_0000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [CNT_W-1:0] nwords,
  input  logic             mode,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned REP = KEY_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       seed_c;
  logic [KEY_W-1:0] adv_c;
  logic             hs_c;

`ifdef OTP_KEYGEN_LFSR_EN
  logic mode_q;

  // Mode is latched once per session, at the accepted start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      mode_q <= mode;
    end
  end

  // An all-zero LFSR never leaves zero, so substitute an all-ones seed byte.
  always_comb begin
    seed_c = seed;
    if (mode && seed == 8'h00) begin
      seed_c = 8'hFF;
    end
  end

  always_comb begin
    adv_c = {shift_q[ROT-1:0], shift_q[KEY_W-1:ROT]};
    if (mode_q) begin
      adv_c = {^(shift_q & TAPS), shift_q[KEY_W-1:1]};
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{mode, TAPS};
  assign seed_c     = seed;
  assign adv_c      = {shift_q[ROT-1:0], shift_q[KEY_W-1:ROT]};
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    hs_c    = key_valid & key_ready;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = {REP{seed_c}};
          cnt_d   = nwords;
          state_d = (nwords == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs_c) begin
          shift_d = adv_c;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      key_valid <= (state_d == RUN);
      busy      <= (state_d != IDLE);
      done      <= (state_d == DONE);
    end
  end

  assign key = shift_q;

endmodule

// File: tb/tb_otp_keygen.sv
// tb_otp_keygen: randomized and directed sessions checked against a word-list model of the key generator.
// Expectations follow OTP_KEYGEN_LFSR_EN when it is defined for the build.
module tb_otp_keygen;

  localparam int unsigned KW   = 16;
  localparam int unsigned RT   = 4;
  localparam int unsigned CW   = 8;
  localparam logic [15:0] TP   = 16'hB400;
`ifdef OTP_KEYGEN_LFSR_EN
  localparam bit LFSR_EN = 1'b1;
`else
  localparam bit LFSR_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic [7:0]    seed;
  logic [CW-1:0] nwords;
  logic          mode;
  logic [KW-1:0] key;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          done;

  int ntests = 0;
  int nfail  = 0;

  otp_keygen #(
    .KEY_W(KW),
    .ROT  (RT),
    .CNT_W(CW),
    .TAPS (TP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .seed     (seed),
    .nwords   (nwords),
    .mode     (mode),
    .key      (key),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next key word: rotate right by RT, or shift right with tap parity entering the MSB.
  function automatic logic [15:0] model_next(input logic [15:0] k, input bit lfsr);
    logic [15:0] r;
    int          ones;
    if (lfsr) begin
      ones = $countones(k & TP);
      r    = k >> 1;
      if ((ones % 2) == 1) r = r | 16'h8000;
    end else begin
      r = (k >> RT) | (k << (KW - RT));
    end
    return r;
  endfunction

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; seed = 8'h00; nwords = '0; mode = 1'b0; key_ready = 1'b0;
    repeat (2) @(negedge clk);
    ntests++;
    if ({key_valid, busy, done, key} !== {3'b000, 16'h0000}) begin
      nfail++;
      $display("FAIL reset_hold got=%h exp=%h", {key_valid, busy, done, key}, {3'b000, 16'h0000});
    end
    reset = 1'b1;
    @(negedge clk);
    ntests++;
    if ({key_valid, busy, done, key} !== {3'b000, 16'h0000}) begin
      nfail++;
      $display("FAIL reset_release got=%h exp=%h", {key_valid, busy, done, key}, {3'b000, 16'h0000});
    end
  endtask

  // One full session from IDLE; returns with the DUT back in IDLE at a negedge.
  task automatic run_session(input logic [7:0] s, input int n, input bit m,
                             input int stall, input bit rnd, input bit spam);
    logic [15:0] exp_q[$];
    logic [15:0] k;
    logic [7:0]  s_eff;
    bit          use_lfsr;
    bit          rdy;
    int          idx;
    int          cyc;
    use_lfsr = LFSR_EN && m;
    s_eff    = (use_lfsr && s == 8'h00) ? 8'hFF : s;
    k        = {s_eff, s_eff};
    for (int i = 0; i <= n; i++) begin
      exp_q.push_back(k);
      k = model_next(k, use_lfsr);
    end
    start = 1'b1; seed = s; nwords = CW'(n); mode = m; key_ready = 1'b0;
    @(negedge clk);
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 300) begin
      start = spam;
      if (spam) begin
        seed = 8'($urandom); nwords = CW'($urandom); mode = 1'($urandom);
      end
      ntests++;
      if ({key_valid, busy, done, key} !== {3'b110, exp_q[idx]}) begin
        nfail++;
        $display("FAIL session_word%0d got=%h exp=%h", idx, {key_valid, busy, done, key},
                 {3'b110, exp_q[idx]});
      end
      rdy = (cyc < stall) ? 1'b0 : (rnd ? 1'($urandom) : 1'b1);
      key_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    if (idx < n) begin
      ntests++;
      nfail++;
      $display("FAIL session_timeout got=%0d words exp=%0d", idx, n);
    end
    start = 1'b0;
    key_ready = 1'($urandom);
    ntests++;
    if ({key_valid, busy, done} !== 3'b011) begin
      nfail++;
      $display("FAIL session_done got=%b exp=%b", {key_valid, busy, done}, 3'b011);
    end
    @(negedge clk);
    ntests++;
    if ({key_valid, busy, done, key} !== {3'b000, exp_q[n]}) begin
      nfail++;
      $display("FAIL session_idle got=%h exp=%h", {key_valid, busy, done, key}, {3'b000, exp_q[n]});
    end
  endtask

  task automatic test_rotate;
    logic [15:0] ex[3];
    ex[0] = 16'h1212; ex[1] = 16'h2121; ex[2] = 16'h1212;
    start = 1'b1; seed = 8'h12; nwords = CW'(3); mode = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ntests++;
      if ({key_valid, busy, done, key} !== {3'b110, ex[i]}) begin
        nfail++;
        $display("FAIL rotate_word%0d got=%h exp=%h", i, {key_valid, busy, done, key}, {3'b110, ex[i]});
      end
      @(negedge clk);
    end
    ntests++;
    if ({key_valid, busy, done, key} !== {3'b011, 16'h2121}) begin
      nfail++;
      $display("FAIL rotate_done got=%h exp=%h", {key_valid, busy, done, key}, {3'b011, 16'h2121});
    end
    @(negedge clk);
    ntests++;
    if ({key_valid, busy, done} !== 3'b000) begin
      nfail++;
      $display("FAIL rotate_idle got=%b exp=%b", {key_valid, busy, done}, 3'b000);
    end
  endtask

  task automatic test_backpressure;
    run_session(8'h12, 3, 1'b0, 5, 1'b0, 1'b0);
    run_session(8'($urandom), 4, 1'b0, 3, 1'b1, 1'b1);
  endtask

  task automatic test_zero_words;
    run_session(8'h5A, 0, 1'b0, 0, 1'b0, 1'b0);
    run_session(8'h00, 0, 1'b1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_lfsr;
    logic [15:0] ex[4];
    logic [7:0]  sd[2];
    ex[0] = 16'h0101;
    ex[1] = LFSR_EN ? 16'h0080 : 16'h1010;
    ex[2] = LFSR_EN ? 16'hFFFF : 16'h0000;
    ex[3] = LFSR_EN ? 16'h7FFF : 16'h0000;
    sd[0] = 8'h01; sd[1] = 8'h00;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; seed = sd[t]; nwords = CW'(2); mode = 1'b1; key_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        ntests++;
        if ({key_valid, key} !== {1'b1, ex[2*t+i]}) begin
          nfail++;
          $display("FAIL lfsr_s%0d_w%0d got=%h exp=%h", t, i, {key_valid, key}, {1'b1, ex[2*t+i]});
        end
        @(negedge clk);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] k;
    k = 16'h3C3C;
    start = 1'b1; seed = 8'h3C; nwords = CW'(5); mode = 1'b0; key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      ntests++;
      if ({key_valid, key} !== {1'b1, k}) begin
        nfail++;
        $display("FAIL midrst_word got=%h exp=%h", {key_valid, key}, {1'b1, k});
      end
      k = model_next(k, 1'b0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    ntests++;
    if ({key_valid, busy, done, key} !== {3'b000, 16'h0000}) begin
      nfail++;
      $display("FAIL midrst_clear got=%h exp=%h", {key_valid, busy, done, key}, {3'b000, 16'h0000});
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ntests++;
      if ({busy, done} !== 2'b00) begin
        nfail++;
        $display("FAIL midrst_nodone got=%b exp=%b", {busy, done}, 2'b00);
      end
    end
    run_session(8'h3C, 2, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_session(8'hA5, 2, 1'b1, 0, 1'b0, 1'b0);
    run_session(8'h00, 1, 1'b1, 0, 1'b0, 1'b0);
    run_session(8'h81, 3, 1'b0, 1, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] s;
    for (int i = 0; i < 30; i++) begin
      s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_session(s, int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 3)),
                  1'b1, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_backpressure();
    test_zero_words();
    test_lfsr();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
